conv_encoder: RTL and testbench
===============================

CONV_ENCODER -- requirements
Module: conv_encoder

Interface
REQ-001 SHALL have parameter SIZE_DATA_IN, default 8, meaning information bits per message.
REQ-002 SHALL have parameter SIZE_DATA_OUT, default 16 (2*SIZE_DATA_IN), meaning coded bits per message.
REQ-003 SHALL have port i_clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  level request to encode i_data; sampled only in IDLE.
REQ-006 SHALL have port i_data  input  SIZE_DATA_IN  message, MSB encoded first.
REQ-007 SHALL have port o_data  output  SIZE_DATA_OUT  codeword; first symbol pair in [15:14].
REQ-008 SHALL have port o_done  output  1  one-cycle pulse; o_data holds a new codeword.
REQ-009 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL implement a rate-1/2, K=3 convolutional code: g0=111, g1=101, u=current bit, s1 and s2 = the previous two bits.
REQ-011 SHALL compute each symbol pair as {g0=u^s1^s2, g1=u^s2}, with g0 in the more-significant position; the state then updates s2<=s1, s1<=u.
REQ-012 SHALL use a state machine with states IDLE, ENCODE and DONE.
REQ-013 SHALL, in IDLE with i_start=1 at a rising edge, latch i_data into an internal PISO register, clear s1/s2 to 0, clear the bit counter, and go to ENCODE.
REQ-014 SHALL, in ENCODE, consume one bit per cycle, MSB first, and shift one pair into an internal SIPO register per cycle, for exactly SIZE_DATA_IN cycles.
REQ-015 SHALL, on the edge that consumes the last bit, load o_data from the SIPO register in full, assert o_done and go to DONE.
REQ-016 SHALL keep o_done high for exactly one cycle; DONE returns to IDLE on the next edge unconditionally.
REQ-017 SHALL assert o_done at the SIZE_DATA_IN-th rising edge after the edge that sampled i_start (8 cycles at default).
REQ-018 SHALL hold o_data unchanged from one completion until the next completion; o_data never shows a partial codeword.
REQ-019 SHALL ignore i_start and i_data in ENCODE and DONE.
REQ-020 SHALL, if i_start is still high on returning to IDLE, start a new encode at the next edge; back-to-back messages repeat every SIZE_DATA_IN+2 cycles.
REQ-021 SHALL start every message from encoder state 00; no state carries over between messages and no tail bits are appended.

Reset
REQ-022 SHALL, when i_rst_n=0 at a rising edge, force IDLE and set o_data=0, o_done=0, o_busy=0, s1=s2=0, counter=0, PISO=0 and SIPO=0.
REQ-023 SHALL, on reset during ENCODE or DONE, abort the message, suppress o_done and keep o_data=0 until a new message completes.
REQ-024 SHALL ignore i_start on any edge where i_rst_n=0.

Configuration
REQ-025 SHALL, when macro CONV_ENC_SERIAL_OUT_EN is defined, add ports o_sym (output, 2 bits) and o_sym_valid (output, 1 bit).
REQ-026 SHALL, with CONV_ENC_SERIAL_OUT_EN defined, register each pair computed in ENCODE onto o_sym with o_sym_valid=1 in the following cycle (exactly 8 valid cycles per message at default), and reset both to 0.
REQ-027 SHALL, without CONV_ENC_SERIAL_OUT_EN, omit these ports and their logic entirely, leaving all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, then i_data=8'hA5 with i_start pulsed for 1 cycle -> o_done at the 8th edge, o_data=16'hE2F8, o_busy high for 9 cycles.
REQ-029 SHALL cover: i_data=8'hFF -> o_data=16'hDAAA; i_data=8'h00 -> o_data=16'h0000.
REQ-030 SHALL cover: i_start held high, i_data=8'hA5 then changed to 8'hFF mid-encode -> first codeword is 16'hE2F8; the next codeword follows 10 cycles later using the value sampled in IDLE.
REQ-031 SHALL cover: i_rst_n=0 on the 4th ENCODE cycle of 8'hA5 -> no o_done, o_data=0, IDLE next cycle; a subsequent 8'hFF yields 16'hDAAA.
REQ-032 SHALL cover: with CONV_ENC_SERIAL_OUT_EN, 8'hA5 -> o_sym sequence 11,10,00,10,11,11,10,00 on 8 consecutive o_sym_valid cycles, with the last pair coincident with o_done.
REQ-033 SHALL cover: i_start pulse during DONE -> ignored; o_done does not re-assert and o_data stays 16'hE2F8.

Source files
------------

// File: rtl/conv_encoder.sv
// Rate-1/2 K=3 convolutional encoder (g0=111, g1=101), one message per start.
// Optional serial symbol output enabled by defining CONV_ENC_SERIAL_OUT_EN.
module conv_encoder #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 2 * SIZE_DATA_IN
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [SIZE_DATA_IN-1:0]  i_data,
  output logic [SIZE_DATA_OUT-1:0] o_data,
  output logic                     o_done,
  output logic                     o_busy
`ifdef CONV_ENC_SERIAL_OUT_EN
  ,
  output logic [1:0]               o_sym,
  output logic                     o_sym_valid
`endif
);

  localparam int CW = $clog2(SIZE_DATA_IN + 1);

  typedef enum logic [1:0] {
    IDLE,
    ENCODE,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SIZE_DATA_IN-1:0]  piso;
  logic [SIZE_DATA_OUT-1:0] sipo;
  logic [SIZE_DATA_OUT-1:0] sipo_nxt;
  logic [CW-1:0]            cnt;
  logic                     s1;
  logic                     s2;
  logic                     u;
  logic [1:0]               pair;
  logic                     last;

  assign u        = piso[SIZE_DATA_IN-1];
  assign pair     = {u ^ s1 ^ s2, u ^ s2};
  assign last     = (cnt == CW'(SIZE_DATA_IN - 1));
  assign sipo_nxt = {sipo[SIZE_DATA_OUT-3:0], pair};
  assign o_busy   = (state != IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: start only sampled in IDLE, DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (i_start) state_nxt = ENCODE;
      ENCODE:  if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch message, shift one bit per cycle, publish full codeword.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      piso   <= '0;
      sipo   <= '0;
      cnt    <= '0;
      s1     <= 1'b0;
      s2     <= 1'b0;
      o_data <= '0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            piso <= i_data;
            sipo <= '0;
            cnt  <= '0;
            s1   <= 1'b0;
            s2   <= 1'b0;
          end
        end
        ENCODE: begin
          piso <= piso << 1;
          sipo <= sipo_nxt;
          s2   <= s1;
          s1   <= u;
          cnt  <= cnt + 1'b1;
          if (last) begin
            o_data <= sipo_nxt;
            o_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CONV_ENC_SERIAL_OUT_EN
  // Serial tap: each pair appears one cycle after it is computed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_sym       <= 2'b00;
      o_sym_valid <= 1'b0;
    end else begin
      o_sym_valid <= (state == ENCODE);
      if (state == ENCODE) o_sym <= pair;
    end
  end
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// Bench for conv_encoder: scoreboard of expected codewords,
// one task per scenario.
module tb_conv_encoder;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [7:0]  i_data;
  logic [15:0] o_data;
  logic        o_done;
  logic        o_busy;
`ifdef CONV_ENC_SERIAL_OUT_EN
  logic [1:0]  o_sym;
  logic        o_sym_valid;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  conv_encoder #(.SIZE_DATA_IN(8), .SIZE_DATA_OUT(16)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (i_start),
    .i_data  (i_data),
    .o_data  (o_data),
    .o_done  (o_done),
    .o_busy  (o_busy)
`ifdef CONV_ENC_SERIAL_OUT_EN
    ,
    .o_sym       (o_sym),
    .o_sym_valid (o_sym_valid)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: encode MSB first from state 00.
  function automatic logic [15:0] model(input logic [7:0] d);
    logic a, b, u;
    logic [15:0] cw;
    a = 1'b0;
    b = 1'b0;
    cw = '0;
    for (int i = 7; i >= 0; i--) begin
      u = d[i];
      cw = {cw[13:0], u ^ a ^ b, u ^ b};
      b = a;
      a = u;
    end
    return cw;
  endfunction

  // Called at the negedge after the start edge; k = edges since start edge.
  task automatic wait_done(output int k, output bit ok);
    k = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_done) begin
        ok = 1;
        break;
      end
      @(negedge i_clk);
      k++;
    end
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_start = 1'b1;
    i_data  = 8'hA5;
    repeat (3) @(negedge i_clk);
    checks++;
    if (o_data !== 16'h0 || o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: data=%h done=%b busy=%b want 0/0/0",
               o_data, o_done, o_busy);
    end
    i_start = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b want 0", o_busy);
    end
  endtask

  task automatic test_basic;
    int k;
    int busy_cnt;
    bit ok;
    i_data = 8'hA5;
    i_start = 1'b1;
    exp_q.push_back(model(8'hA5));
    @(negedge i_clk);
    i_start = 1'b0;
    busy_cnt = 0;
    k = 0;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (o_busy) busy_cnt++;
      if (o_done) begin
        ok = 1;
        break;
      end
      @(negedge i_clk);
      k++;
    end
    checks++;
    if (!ok || k != 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d edges (ok=%b) want 8", k, ok);
    end
    exp = exp_q.pop_front();
    checks++;
    if (o_data !== exp || o_data !== 16'hE2F8) begin
      errors++;
      $display("FAIL basic_data: got %h want %h", o_data, exp);
    end
    @(negedge i_clk);
    if (o_busy) busy_cnt++;
    checks++;
    if (busy_cnt != 9) begin
      errors++;
      $display("FAIL basic_busy: got %0d cycles want 9", busy_cnt);
    end
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse: done=%b busy=%b want 0/0", o_done, o_busy);
    end
  endtask

  task automatic test_start_in_done;
    int k;
    bit ok;
    i_data = 8'hA5;
    i_start = 1'b1;
    exp_q.push_back(model(8'hA5));
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(k, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || o_data !== exp) begin
      errors++;
      $display("FAIL done_first: got %h (ok=%b) want %h", o_data, ok, exp);
    end
    i_start = 1'b1;
    i_data = 8'hFF;
    @(negedge i_clk);
    i_start = 1'b0;
    ok = 1;
    for (int i = 0; i < 12; i++) begin
      if (o_done || o_busy || o_data !== 16'hE2F8) ok = 0;
      @(negedge i_clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_in_done: data=%h done=%b busy=%b want E2F8/0/0",
               o_data, o_done, o_busy);
    end
  endtask

  task automatic test_patterns;
    logic [7:0] pats[4];
    logic [15:0] prev;
    int k;
    bit ok;
    bit hold;
    pats[0] = 8'hFF;
    pats[1] = 8'h00;
    pats[2] = 8'h3C;
    pats[3] = 8'h81;
    for (int p = 0; p < 4; p++) begin
      prev = o_data;
      i_data = pats[p];
      i_start = 1'b1;
      exp_q.push_back(model(pats[p]));
      @(negedge i_clk);
      i_start = 1'b0;
      hold = 1;
      ok = 0;
      k = 0;
      for (int i = 0; i < 30; i++) begin
        if (o_done) begin
          ok = 1;
          break;
        end
        if (o_data !== prev) hold = 0;
        @(negedge i_clk);
        k++;
      end
      exp = exp_q.pop_front();
      checks++;
      if (!ok || k != 8 || o_data !== exp || !hold) begin
        errors++;
        $display("FAIL pattern_%h: got %h k=%0d hold=%b want %h k=8",
                 pats[p], o_data, k, hold, exp);
      end
      if (p == 0) begin
        checks++;
        if (o_data !== 16'hDAAA) begin
          errors++;
          $display("FAIL pattern_ff_const: got %h want DAAA", o_data);
        end
      end
      if (p == 1) begin
        checks++;
        if (o_data !== 16'h0000) begin
          errors++;
          $display("FAIL pattern_00_const: got %h want 0000", o_data);
        end
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    bit ok;
    i_data = 8'hA5;
    i_start = 1'b1;
    exp_q.push_back(model(8'hA5));
    @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    i_data = 8'hFF;
    exp_q.push_back(model(8'hFF));
    wait_done(k, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || k != 5 || o_data !== exp || o_data !== 16'hE2F8) begin
      errors++;
      $display("FAIL b2b_first: got %h k=%0d want %h k=5", o_data, k, exp);
    end
    @(negedge i_clk);
    wait_done(k, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || k + 1 != 10 || o_data !== exp || o_data !== 16'hDAAA) begin
      errors++;
      $display("FAIL b2b_second: got %h gap=%0d want %h gap=10",
               o_data, k + 1, exp);
    end
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset_mid;
    int k;
    bit ok;
    bit seen;
    i_data = 8'hA5;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    checks++;
    if (o_done !== 1'b0 || o_data !== 16'h0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: done=%b data=%h busy=%b want 0/0000/0",
               o_done, o_data, o_busy);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_done || o_data !== 16'h0) seen = 1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL reset_abort: done=%b data=%h want 0/0000", o_done, o_data);
    end
    i_data = 8'hFF;
    i_start = 1'b1;
    exp_q.push_back(model(8'hFF));
    @(negedge i_clk);
    i_start = 1'b0;
    wait_done(k, ok);
    exp = exp_q.pop_front();
    checks++;
    if (!ok || o_data !== exp || o_data !== 16'hDAAA) begin
      errors++;
      $display("FAIL reset_then_ff: got %h want %h", o_data, exp);
    end
    @(negedge i_clk);
  endtask

`ifdef CONV_ENC_SERIAL_OUT_EN
  task automatic test_serial;
    logic [1:0] sym_q[$];
    logic [1:0] es;
    int nvalid;
    bit last_ok;
    bit bad;
    logic [15:0] cw;
    cw = model(8'hA5);
    for (int i = 7; i >= 0; i--) sym_q.push_back(cw[2*i +: 2]);
    i_data = 8'hA5;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    nvalid = 0;
    last_ok = 0;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (o_sym_valid) begin
        nvalid++;
        if (sym_q.size() == 0) begin
          bad = 1;
        end else begin
          es = sym_q.pop_front();
          if (o_sym !== es) bad = 1;
          if (sym_q.size() == 0 && o_done) last_ok = 1;
        end
      end
      @(negedge i_clk);
    end
    checks++;
    if (bad || nvalid != 8 || !last_ok) begin
      errors++;
      $display("FAIL serial: n=%0d bad=%b last_ok=%b want 8/0/1",
               nvalid, bad, last_ok);
    end
  endtask
`endif

  initial begin
    i_rst_n = 1'b0;
    i_start = 1'b0;
    i_data  = 8'h00;
    test_reset;
    test_basic;
    test_start_in_done;
    test_patterns;
    test_back_to_back;
    test_reset_mid;
`ifdef CONV_ENC_SERIAL_OUT_EN
    test_serial;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
